// File: rtl/sysbus_mem_responder.sv
// rtl/sysbus_mem_responder.sv - Sysbus memory responder serving 8-beat line reads/writes
// Optional: define SYSBUS_MEM_STALL_EN to drop respcyc for one cycle after beat 3 is acked.
module sysbus_mem_responder #(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int DEPTH_WORDS    = 4096,
   parameter int LATENCY        = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      bus_reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] bus_req,
   input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
   output logic                      bus_reqack,
   output logic                      bus_respcyc,
   output logic [BUS_DATA_WIDTH-1:0] bus_resp,
   output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
   input  logic                      bus_respack
);

   localparam int AW = $clog2(DEPTH_WORDS);
   // Only the line index inside the array is kept; the offset within a line is ignored.
   localparam int LW = AW - 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACK,
      S_WAIT,
      S_RESP,
      S_WR_DATA
   } state_t;

   state_t                    state_q, state_d;
   logic [LW-1:0]             line_q, line_d;
   logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_d;
   logic [2:0]                beat_q, beat_d;
   logic [7:0]                cnt_q, cnt_d;
   logic                      stall_q, stall_d;
   logic                      reqack_q, reqack_d;
   logic                      respcyc_q, respcyc_d;
   logic [BUS_DATA_WIDTH-1:0] resp_q, resp_d;
   logic [BUS_TAG_WIDTH-1:0]  resptag_q, resptag_d;
   logic                      wr_en;

   logic [BUS_DATA_WIDTH-1:0] mem [DEPTH_WORDS];

   always_comb begin
      state_d   = state_q;
      line_d    = line_q;
      tag_d     = tag_q;
      beat_d    = beat_q;
      cnt_d     = cnt_q;
      stall_d   = 1'b0;
      reqack_d  = 1'b0;
      wr_en     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus_reqcyc) begin
               line_d   = bus_req[AW+2:6];
               tag_d    = bus_reqtag;
               reqack_d = 1'b1;
               state_d  = S_ACK;
            end
         end
         S_ACK: begin
            beat_d = 3'd0;
            if (tag_q[BUS_TAG_WIDTH-1]) begin
               // WAIT holds for LATENCY-1 cycles so the first beat lands LATENCY cycles after the ack.
               if (LATENCY == 1) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 8'(LATENCY - 1);
               end
            end else begin
               state_d = S_WR_DATA;
            end
         end
         S_WAIT: begin
            if (cnt_q == 8'd1) begin
               state_d = S_RESP;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_RESP: begin
            if (!stall_q && bus_respack) begin
               beat_d = beat_q + 3'd1;
               if (beat_q == 3'd7) begin
                  state_d = S_IDLE;
               end
`ifdef SYSBUS_MEM_STALL_EN
               if (beat_q == 3'd3) begin
                  stall_d = 1'b1;
               end
`endif
            end
         end
         S_WR_DATA: begin
            if (bus_reqcyc) begin
               wr_en  = 1'b1;
               beat_d = beat_q + 3'd1;
               if (beat_q == 3'd7) begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Response outputs are registered from the next-cycle state and beat.
      respcyc_d = (state_d == S_RESP) && !stall_d;
      resp_d    = respcyc_d ? mem[{line_d, beat_d}] : '0;
      resptag_d = respcyc_d ? tag_d : '0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         line_q    <= '0;
         tag_q     <= '0;
         beat_q    <= 3'd0;
         cnt_q     <= 8'd0;
         stall_q   <= 1'b0;
         reqack_q  <= 1'b0;
         respcyc_q <= 1'b0;
         resp_q    <= '0;
         resptag_q <= '0;
      end else begin
         state_q   <= state_d;
         line_q    <= line_d;
         tag_q     <= tag_d;
         beat_q    <= beat_d;
         cnt_q     <= cnt_d;
         stall_q   <= stall_d;
         reqack_q  <= reqack_d;
         respcyc_q <= respcyc_d;
         resp_q    <= resp_d;
         resptag_q <= resptag_d;
      end
   end

   // Storage survives reset; only a write beat taken while out of reset lands.
   always_ff @(posedge clk) begin
      if (reset && wr_en) begin
         mem[{line_q, beat_q}] <= bus_req;
      end
   end

   // Write beats are acknowledged in the very cycle they are presented.
   assign bus_reqack  = reqack_q | ((state_q == S_WR_DATA) && bus_reqcyc);
   assign bus_respcyc = respcyc_q;
   assign bus_resp    = resp_q;
   assign bus_resptag = resptag_q;

endmodule
